// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, requester indices and width defaults for the port-B arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_e;
    localparam int REQ_DISP = 0;
    localparam int REQ_IO = 1;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v == 8'hFF ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes plus the RAM port-B bus.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = ram_arb_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH_DEF
);
    logic                  req0, req1, we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_data_b, ram_q_b;
    logic                  ram_we_b;
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q_b,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr_b, ram_data_b, ram_we_b
    );
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q_b,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr_b, ram_data_b, ram_we_b
    );
endinterface

// File: rtl/rr_grant2.sv
// rr_grant2: combinational two-way round-robin grant with a bounded burst per owner.
module rr_grant2 import ram_arb_pkg::*; #(
    parameter int BURST_MAX = 8
) (
    input  arb_state_e state,
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    input  logic [7:0] burst_cnt,
    output logic       gnt0,
    output logic       gnt1
);
    localparam logic [7:0] LIMIT = 8'(BURST_MAX - 1);
    logic keep0, keep1;
    // The owner keeps the port until it drops req or exhausts its burst while the other waits.
    assign keep0 = req0 && (!req1 || burst_cnt < LIMIT);
    assign keep1 = req1 && (!req0 || burst_cnt < LIMIT);
    always_comb begin
        gnt0 = state == OWN0 ? keep0 : state == OWN1 ? !keep1 && req0 : req0 && (!req1 || last_owner);
        gnt1 = state == OWN1 ? keep1 : state == OWN0 ? !keep0 && req1 : req1 && (!req0 || !last_owner);
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port B between display fetch (0) and I/O-DMA (1).
// Define RAM_ARB_ADDR_GUARD_EN to block accesses to the unpopulated upper bank and add guard_err.
module ram_port_arbiter import ram_arb_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BURST_MAX = 8
) (
    input logic clk,
    input logic reset,
    ram_port_arbiter_if.slave bus
`ifdef RAM_ARB_ADDR_GUARD_EN
    , output logic guard_err
`endif
);
    arb_state_e            state, state_d;
    logic [7:0]            burst_cnt, burst_cnt_d;
    logic                  last_owner, last_owner_d;
    logic                  g0, g1, gnt0, gnt1, any, g_we, blk, rv, rd_owner;
    logic [ADDR_WIDTH-1:0] g_addr, addr_q;
    logic [DATA_WIDTH-1:0] g_data;

    rr_grant2 #(.BURST_MAX(BURST_MAX)) u_grant (
        .state(state),
        .req0(bus.req0),
        .req1(bus.req1),
        .last_owner(last_owner),
        .burst_cnt(burst_cnt),
        .gnt0(g0),
        .gnt1(g1)
    );

    // Grants are forced low for as long as reset is held.
    assign gnt0 = g0 & reset;
    assign gnt1 = g1 & reset;
    assign any = gnt0 | gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            burst_cnt <= 8'd0;
            last_owner <= 1'b1;
        end else begin
            state <= state_d;
            burst_cnt <= burst_cnt_d;
            last_owner <= last_owner_d;
        end
    end

    always_comb begin
        state_d = gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
        burst_cnt_d = state_d != IDLE && state_d == state ? sat_inc(burst_cnt) : 8'd0;
        last_owner_d = gnt0 ? 1'(REQ_DISP) : gnt1 ? 1'(REQ_IO) : last_owner;
    end

    always_comb begin
        g_addr = gnt1 ? bus.addr1 : bus.addr0;
        g_data = gnt1 ? bus.wdata1 : bus.wdata0;
        g_we = gnt1 ? bus.we1 : bus.we0;
    end

`ifdef RAM_ARB_ADDR_GUARD_EN
    logic rd_guard;
    assign blk = any & g_addr[ADDR_WIDTH-1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_guard <= 1'b0;
            guard_err <= 1'b0;
        end else begin
            rd_guard <= blk & ~g_we;
            guard_err <= blk;
        end
    end
    assign bus.rdata = rd_guard ? '0 : bus.ram_q_b;
`else
    assign blk = 1'b0;
    assign bus.rdata = bus.ram_q_b;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rv <= 1'b0;
            rd_owner <= 1'b0;
            addr_q <= '0;
        end else begin
            rv <= any & ~g_we;
            rd_owner <= gnt1;
            addr_q <= any ? g_addr : addr_q;
        end
    end

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;
    assign bus.rvalid0 = rv & ~rd_owner;
    assign bus.rvalid1 = rv & rd_owner;
    assign bus.ram_addr_b = any ? g_addr : addr_q;
    assign bus.ram_data_b = any ? g_data : '0;
    assign bus.ram_we_b = any & g_we & ~blk;
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares port B of the 16-bit dual-port data RAM between two requesters: requester 0 (display/VGA fetch) and requester 1 (memory-mapped I/O / DMA).
- Port A stays owned by the CPU and does not pass through this block.
- Round-robin arbitration with a bounded burst length.
- Same-cycle combinational grant, one transfer per cycle, read data returned one cycle after grant.

Parameters:
- DATA_WIDTH, 16, word width; matches RAM.
- ADDR_WIDTH, 10, word address width; matches RAM.
- BURST_MAX, 8, maximum consecutive grants to one owner while the other requester is waiting; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  transfer request, held until granted.
- we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
- addr0, addr1  input  ADDR_WIDTH each  word address.
- wdata0, wdata1  input  DATA_WIDTH each  write data.
- gnt0, gnt1  output  1 each  combinational grant; the transfer happens in the cycle where req and gnt are both high.
- rvalid0, rvalid1  output  1 each  read data valid, registered.
- rdata  output  DATA_WIDTH  read data, shared bus; qualified by rvalid0 or rvalid1.
- ram_addr_b  output  ADDR_WIDTH  to RAM addr_b.
- ram_data_b  output  DATA_WIDTH  to RAM data_b.
- ram_we_b  output  1  to RAM we_b.
- ram_q_b  input  DATA_WIDTH  from RAM q_b_out.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, burst_cnt=0, last_owner=1 (so requester 0 wins the first tie).
  - rvalid0=rvalid1=0, rd_owner=0.
  - gnt0=gnt1=0 and ram_we_b=0 while reset is low.
- States:
  - IDLE: no owner.
  - OWN0: requester 0 owns the port.
  - OWN1: requester 1 owns the port.
- Grant logic (combinational, from state, req, burst_cnt):
  - IDLE: a sole requester is granted; if both request, the requester != last_owner is granted.
  - OWNx: x keeps the grant while reqx=1 and (other req=0 or burst_cnt < BURST_MAX-1).
  - OWNx, x drops req: the other requester is granted in the same cycle if it is requesting.
  - OWNx, burst_cnt reaches BURST_MAX-1 with the other requesting: the grant passes to the other requester next cycle.
  - Exactly one gnt is high at a time; gnt is never high without its req.
- Next state:
  - State follows the granted requester; IDLE if neither is granted.
  - last_owner updates to the granted index.
  - burst_cnt increments on a continued grant to the same owner, resets to 0 on a change of owner or on IDLE.
  - burst_cnt saturates; it never wraps.
- RAM drive:
  - ram_addr_b, ram_data_b and ram_we_b are muxed combinationally from the granted requester.
  - With no grant: ram_we_b=0, ram_addr_b holds the last granted address (register), ram_data_b=0.
- Read return:
  - A granted read at edge T sets rvalid<owner>=1 for exactly the cycle after T; rdata=ram_q_b in that cycle.
  - rd_owner is registered; rvalid is never asserted for writes.
- Write: committed by the RAM at the grant edge; no acknowledge beyond gnt.
- Back-to-back:
  - Reads on consecutive cycles by different owners yield alternating rvalid0/rvalid1 pulses with no bubbles.
- Simultaneous write on port A to the same address: RAM-defined; the arbiter takes no action.
- Reset mid-burst: an outstanding rvalid is cleared and read data is dropped; requesters must reissue.

Optional Feature:
- RAM_ARB_ADDR_GUARD_EN: protects the unpopulated upper RAM bank (addr[ADDR_WIDTH-1]=1).
- When defined:
  - A granted write to the upper half forces ram_we_b=0.
  - A granted read to the upper half returns rdata=0 with the normal rvalid timing.
  - Output guard_err (1 bit, registered) pulses for one cycle after any such access.
- When undefined:
  - No guard_err port; upper-half accesses pass through unchanged.

Decomposition:
- Shared package ram_arb_pkg:
  - state encoding IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - requester index constants REQ_DISP=0, REQ_IO=1.
  - DATA_WIDTH and ADDR_WIDTH defaults.
- One sub-module: rr_grant2, the combinational two-way round-robin/burst grant function; the FSM, counters and read-return registers stay in the top.

Test Plan:
- Reset low, req0=req1=1 → gnt0=gnt1=0, ram_we_b=0. After reset releases → gnt0=1 first cycle.
- req0 only, read addr 0x005 (RAM holds 0x1234) → gnt0 same cycle, ram_addr_b=0x005; next cycle rvalid0=1, rdata=0x1234, rvalid1=0.
- req0 and req1 held continuously, BURST_MAX=8 → gnt0 for 8 cycles, gnt1 for 8, repeating; never both high.
- req1 write 0xBEEF to 0x010, then req0 read 0x010 next cycle → ram_we_b=1 for one cycle; rvalid0 two cycles after write grant with rdata=0xBEEF.
- Alternating single-cycle reads req0/req1 → rvalid0/rvalid1 alternate every cycle; rdata matches each address.
- Guard enabled, req1 write 0x0AAA to 0x200 → ram_we_b=0, guard_err pulse; read 0x200 → rdata=0x0000, rvalid1=1.
